// File: rtl/cpu_bus_ctrl_pkg.sv
// rtl/cpu_bus_ctrl_pkg.sv - shared bus definitions: source-select encoding, IO strobe indices, open-bus default
package cpu_bus_ctrl_pkg;

    // Read-data source captured on each read access.
    typedef enum logic [2:0] {
        SEL_NONE    = 3'd0,
        SEL_RAM     = 3'd1,
        SEL_BASIC   = 3'd2,
        SEL_MONITOR = 3'd3,
        SEL_UART    = 3'd4,
        SEL_GPU     = 3'd5,
        SEL_LCD     = 3'd6,
        SEL_PS2     = 3'd7
    } sel_e;

    // Bit positions inside io_rd_stb / io_wr_stb and the device-select vector.
    localparam int IO_UART = 0;
    localparam int IO_GPU  = 1;
    localparam int IO_LCD  = 2;
    localparam int IO_PS2  = 3;

    localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

    // Fixed-priority encode: RAM > BASIC > MONITOR > UART > GPU > LCD > PS2.
    function automatic sel_e encode_sel(input logic ram, input logic basic,
                                        input logic monitor, input logic [3:0] dev);
        sel_e s;
        s = SEL_NONE;
        if (ram)               s = SEL_RAM;
        else if (basic)        s = SEL_BASIC;
        else if (monitor)      s = SEL_MONITOR;
        else if (dev[IO_UART]) s = SEL_UART;
        else if (dev[IO_GPU])  s = SEL_GPU;
        else if (dev[IO_LCD])  s = SEL_LCD;
        else if (dev[IO_PS2])  s = SEL_PS2;
        return s;
    endfunction

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// rtl/cpu_bus_ctrl_if.sv - CPU-side bus, decoder selects, device read data and strobes
interface cpu_bus_ctrl_if;
    logic       cpu_ce;
    logic       cpu_we;
    logic [7:0] cpu_dout;
    logic       ram_cs;
    logic       rom_basic_cs;
    logic       rom_monitor_cs;
    logic       io_cs;
    logic       uart_cs;
    logic       gpu_cs;
    logic       lcd_cs;
    logic       ps2_cs;
    logic [7:0] ram_rdata;
    logic [7:0] rom_basic_rdata;
    logic [7:0] rom_monitor_rdata;
    logic [7:0] uart_rdata;
    logic [7:0] gpu_rdata;
    logic [7:0] lcd_rdata;
    logic [7:0] ps2_rdata;
    logic [7:0] cpu_din;
    logic       ram_we;
    logic [3:0] io_rd_stb;
    logic [3:0] io_wr_stb;

    // Controller side.
    modport slave (
        input  cpu_ce, cpu_we, cpu_dout,
        input  ram_cs, rom_basic_cs, rom_monitor_cs, io_cs,
        input  uart_cs, gpu_cs, lcd_cs, ps2_cs,
        input  ram_rdata, rom_basic_rdata, rom_monitor_rdata,
        input  uart_rdata, gpu_rdata, lcd_rdata, ps2_rdata,
        output cpu_din, ram_we, io_rd_stb, io_wr_stb
    );

    // CPU/decoder/device side.
    modport master (
        output cpu_ce, cpu_we, cpu_dout,
        output ram_cs, rom_basic_cs, rom_monitor_cs, io_cs,
        output uart_cs, gpu_cs, lcd_cs, ps2_cs,
        output ram_rdata, rom_basic_rdata, rom_monitor_rdata,
        output uart_rdata, gpu_rdata, lcd_rdata, ps2_rdata,
        input  cpu_din, ram_we, io_rd_stb, io_wr_stb
    );
endinterface

// File: rtl/sat_counter8.sv
// rtl/sat_counter8.sv - 8-bit saturating up-counter with priority clear
module sat_counter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] cnt_o
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Clear beats increment; increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 8'h00;
        else if (inc_i && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'h00;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - decoder selects to single-cycle strobes, read-data mux, open bus, illegal-access count
module cpu_bus_ctrl
    import cpu_bus_ctrl_pkg::*;
#(
    parameter logic [7:0] OPEN_BUS_INIT = OPEN_BUS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    cpu_bus_ctrl_if.slave     bus,
    input  logic              err_clr,
    output logic [7:0]        err_cnt,
    output logic              err_flag
);
    logic [3:0] dev_cs;
    logic       acc;
    logic       any_dev;
    logic       illegal;
    sel_e       sel_q, sel_d;
    logic [7:0] ob_q, ob_d;
    logic       rd_q, rd_d;
    logic       err_flag_q, err_flag_d;

    // Gather device selects in strobe-index order; access is gated by reset so strobes drop immediately.
    always_comb begin
        dev_cs          = 4'b0000;
        dev_cs[IO_UART] = bus.uart_cs;
        dev_cs[IO_GPU]  = bus.gpu_cs;
        dev_cs[IO_LCD]  = bus.lcd_cs;
        dev_cs[IO_PS2]  = bus.ps2_cs;
        any_dev         = |dev_cs;
        acc             = bus.cpu_ce & ~rst;
        illegal         = acc & ((bus.cpu_we & (bus.rom_basic_cs | bus.rom_monitor_cs))
                                 | (bus.io_cs & ~any_dev));
    end

    // Strobes are purely combinational from qualified selects; ROM writes have no strobe.
    always_comb begin
        bus.ram_we    = acc & bus.cpu_we & bus.ram_cs;
        bus.io_wr_stb = {4{acc &  bus.cpu_we}} & dev_cs;
        bus.io_rd_stb = {4{acc & ~bus.cpu_we}} & dev_cs;
    end

    // Read-data mux; NONE returns the open-bus value.
    always_comb begin
        case (sel_q)
            SEL_RAM:     bus.cpu_din = bus.ram_rdata;
            SEL_BASIC:   bus.cpu_din = bus.rom_basic_rdata;
            SEL_MONITOR: bus.cpu_din = bus.rom_monitor_rdata;
            SEL_UART:    bus.cpu_din = bus.uart_rdata;
            SEL_GPU:     bus.cpu_din = bus.gpu_rdata;
            SEL_LCD:     bus.cpu_din = bus.lcd_rdata;
            SEL_PS2:     bus.cpu_din = bus.ps2_rdata;
            default:     bus.cpu_din = ob_q;
        endcase
    end

    // Next state for source select, open-bus latch, read tracker and sticky flag.
    always_comb begin
        sel_d      = sel_q;
        ob_d       = ob_q;
        rd_d       = acc & ~bus.cpu_we;
        err_flag_d = err_flag_q;
        if (acc)
            sel_d = bus.cpu_we ? SEL_NONE
                               : encode_sel(bus.ram_cs, bus.rom_basic_cs, bus.rom_monitor_cs, dev_cs);
        // A write is the newest bus value, so it wins over capturing last read's data.
        if (acc && bus.cpu_we)
            ob_d = bus.cpu_dout;
        else if (rd_q && (sel_q != SEL_NONE))
            ob_d = bus.cpu_din;
        if (err_clr)
            err_flag_d = 1'b0;
        else if (illegal)
            err_flag_d = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= SEL_NONE;
            ob_q       <= OPEN_BUS_INIT;
            rd_q       <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            ob_q       <= ob_d;
            rd_q       <= rd_d;
            err_flag_q <= err_flag_d;
        end
    end

    sat_counter8 u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (err_clr),
        .inc_i (illegal),
        .cnt_o (err_cnt)
    );

    assign err_flag = err_flag_q;
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb/tb_cpu_bus_ctrl.sv - directed self-checking bench for cpu_bus_ctrl
module tb_cpu_bus_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       err_clr;
    logic [7:0] err_cnt;
    logic       err_flag;
    int         n_total = 0;
    int         n_pass  = 0;

    cpu_bus_ctrl_if bus ();

    cpu_bus_ctrl #(.OPEN_BUS_INIT(8'hFF)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .err_clr  (err_clr),
        .err_cnt  (err_cnt),
        .err_flag (err_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive inputs just after the rising edge; checks follow at the falling edge.
    task automatic idle();
        bus.cpu_ce = 0; bus.cpu_we = 0; bus.cpu_dout = 8'h00;
        bus.ram_cs = 0; bus.rom_basic_cs = 0; bus.rom_monitor_cs = 0; bus.io_cs = 0;
        bus.uart_cs = 0; bus.gpu_cs = 0; bus.lcd_cs = 0; bus.ps2_cs = 0;
        err_clr = 0; rst = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        bus.ram_rdata = 8'h00; bus.rom_basic_rdata = 8'h11; bus.rom_monitor_rdata = 8'h22;
        bus.uart_rdata = 8'hC3; bus.gpu_rdata = 8'h00; bus.lcd_rdata = 8'h00; bus.ps2_rdata = 8'h33;
        idle();
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        idle();

        // Reset then idle
        mid();
        chk("reset_din", {1'b0, bus.cpu_din}, 9'h0FF);
        chk("reset_err_cnt", {1'b0, err_cnt}, 9'h000);
        chk("reset_err_flag", {8'h00, err_flag}, 9'h000);
        chk("reset_strobes", {bus.ram_we, bus.io_rd_stb, bus.io_wr_stb}, 9'h000);

        // RAM write 5A
        next_cycle();
        bus.cpu_ce = 1; bus.cpu_we = 1; bus.ram_cs = 1; bus.cpu_dout = 8'h5A;
        bus.ram_rdata = 8'h5A;
        mid();
        chk("ram_we_on", {8'h00, bus.ram_we}, 9'h001);
        next_cycle();
        mid();
        chk("ram_we_off", {8'h00, bus.ram_we}, 9'h000);

        // RAM read, then reserved-IO read back-to-back
        next_cycle();
        bus.cpu_ce = 1; bus.ram_cs = 1;
        mid();
        chk("ram_rd_no_we", {8'h00, bus.ram_we}, 9'h000);
        next_cycle();
        bus.cpu_ce = 1; bus.io_cs = 1;
        mid();
        chk("ram_rd_din", {1'b0, bus.cpu_din}, 9'h05A);
        chk("rsvd_no_stb", {bus.ram_we, bus.io_rd_stb, bus.io_wr_stb}, 9'h000);
        next_cycle();
        bus.ram_rdata = 8'h00;
        mid();
        chk("rsvd_open_bus", {1'b0, bus.cpu_din}, 9'h05A);
        chk("rsvd_err_cnt", {1'b0, err_cnt}, 9'h001);
        chk("rsvd_err_flag", {8'h00, err_flag}, 9'h001);

        // UART read followed by 3-cycle stall
        next_cycle();
        bus.cpu_ce = 1; bus.io_cs = 1; bus.uart_cs = 1;
        mid();
        chk("uart_rd_stb", {5'h00, bus.io_rd_stb}, 9'h001);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            mid();
            chk("uart_stall_stb", {5'h00, bus.io_rd_stb}, 9'h000);
            chk("uart_din", {1'b0, bus.cpu_din}, 9'h0C3);
        end
        chk("uart_err_cnt", {1'b0, err_cnt}, 9'h001);

        // Back-to-back BASIC, MONITOR, PS2 reads
        next_cycle();
        bus.cpu_ce = 1; bus.rom_basic_cs = 1;
        mid();
        chk("b2b_basic_stb", {5'h00, bus.io_rd_stb}, 9'h000);
        next_cycle();
        bus.cpu_ce = 1; bus.rom_monitor_cs = 1;
        mid();
        chk("b2b_din_basic", {1'b0, bus.cpu_din}, 9'h011);
        chk("b2b_mon_stb", {5'h00, bus.io_rd_stb}, 9'h000);
        next_cycle();
        bus.cpu_ce = 1; bus.io_cs = 1; bus.ps2_cs = 1;
        mid();
        chk("b2b_din_monitor", {1'b0, bus.cpu_din}, 9'h022);
        chk("b2b_ps2_stb", {5'h00, bus.io_rd_stb}, 9'h008);
        next_cycle();
        mid();
        chk("b2b_din_ps2", {1'b0, bus.cpu_din}, 9'h033);

        // Priority: RAM and BASIC both selected, RAM wins
        bus.ram_rdata = 8'hA7;
        next_cycle();
        bus.cpu_ce = 1; bus.ram_cs = 1; bus.rom_basic_cs = 1;
        next_cycle();
        mid();
        chk("prio_ram_din", {1'b0, bus.cpu_din}, 9'h0A7);

        // 300 monitor-ROM writes
        for (int i = 0; i < 300; i++) begin
            next_cycle();
            bus.cpu_ce = 1; bus.cpu_we = 1; bus.rom_monitor_cs = 1; bus.cpu_dout = 8'(i);
            mid();
            chk("rom_wr_no_stb", {bus.ram_we, bus.io_rd_stb, bus.io_wr_stb}, 9'h000);
        end
        next_cycle();
        mid();
        chk("sat_err_cnt", {1'b0, err_cnt}, 9'h0FF);
        chk("sat_err_flag", {8'h00, err_flag}, 9'h001);

        // err_clr coinciding with a ROM write
        next_cycle();
        bus.cpu_ce = 1; bus.cpu_we = 1; bus.rom_monitor_cs = 1; bus.cpu_dout = 8'h77;
        err_clr = 1;
        next_cycle();
        mid();
        chk("clr_err_cnt", {1'b0, err_cnt}, 9'h000);
        chk("clr_err_flag", {8'h00, err_flag}, 9'h000);
        chk("clr_open_bus", {1'b0, bus.cpu_din}, 9'h077);

        // Plain GPU write
        next_cycle();
        bus.cpu_ce = 1; bus.cpu_we = 1; bus.io_cs = 1; bus.gpu_cs = 1; bus.cpu_dout = 8'h44;
        mid();
        chk("gpu_wr_stb", {5'h00, bus.io_wr_stb}, 9'h002);
        next_cycle();
        mid();
        chk("gpu_wr_open_bus", {1'b0, bus.cpu_din}, 9'h044);

        // GPU write with reset in the same cycle
        next_cycle();
        bus.cpu_ce = 1; bus.cpu_we = 1; bus.io_cs = 1; bus.gpu_cs = 1; bus.cpu_dout = 8'h99;
        rst = 1;
        mid();
        chk("rst_gpu_wr_stb", {5'h00, bus.io_wr_stb}, 9'h000);
        next_cycle();
        mid();
        chk("rst_din", {1'b0, bus.cpu_din}, 9'h0FF);
        chk("rst_err_cnt", {1'b0, err_cnt}, 9'h000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
